// File: rtl/seq_mult_hs_if.sv
// Operand/result handshake bundle for seq_mult_hs. The master is the producer/consumer side.
// The slave is the multiplier itself.
interface seq_mult_hs_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   signed_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_hs.sv
// Iterative shift-and-add multiplier with valid/ready handshakes, optional signed mode
// and early exit once the remaining multiplier bits are all zero.
module seq_mult_hs #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seq_mult_hs_if.slave      bus,
  output logic [1:0]        state_dbg
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   mcand, mcand_nx;
  logic [PW-1:0]   acc, acc_nx;
  logic [PW-1:0]   product_r, product_nx;
  logic [WIDTH-1:0] mplr, mplr_nx;
  logic            neg, neg_nx;
  logic            out_valid_r, out_valid_nx;
  logic            sm;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready depends only on state; out_valid/product stay stable until out_ready is seen.
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;
  assign state_dbg     = state;

  // Operands are reduced to magnitudes so the loop is purely unsigned.
  always_comb begin
    sm    = bus.signed_mode & SIGNED_EN;
    a_mag = (sm && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag = (sm && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
  end

  always_comb begin
    state_nx     = state;
    mcand_nx     = mcand;
    mplr_nx      = mplr;
    acc_nx       = acc;
    neg_nx       = neg;
    product_nx   = product_r;
    out_valid_nx = out_valid_r;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_nx = PW'(a_mag);
          mplr_nx  = b_mag;
          acc_nx   = '0;
          neg_nx   = sm & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          state_nx = RUN;
        end
      end
      RUN: begin
        if (mplr == '0) begin
          // A zero magnitude negates to zero, so neg needs no special case.
          product_nx   = neg ? (~acc + PW'(1)) : acc;
          out_valid_nx = 1'b1;
          state_nx     = DONE;
        end else begin
          if (mplr[0]) acc_nx = acc + mcand;
          mcand_nx = mcand << 1;
          mplr_nx  = mplr >> 1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mcand       <= '0;
      mplr        <= '0;
      acc         <= '0;
      neg         <= 1'b0;
      product_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state       <= state_nx;
      mcand       <= mcand_nx;
      mplr        <= mplr_nx;
      acc         <= acc_nx;
      neg         <= neg_nx;
      product_r   <= product_nx;
      out_valid_r <= out_valid_nx;
    end
  end
endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed bench for seq_mult_hs: hand-computed products and latencies, backpressure,
// mid-operation reset and the SIGNED_EN=0 build.
module tb_seq_mult_hs;
  logic       clk;
  logic       rst;
  logic [1:0] state_s;
  logic [1:0] state_u;
  int         checks;
  int         errors;

  seq_mult_hs_if #(.WIDTH(8)) bus_s ();
  seq_mult_hs_if #(.WIDTH(8)) bus_u ();

  seq_mult_hs #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_s.slave),
    .state_dbg (state_s)
  );

  seq_mult_hs #(.WIDTH(8), .SIGNED_EN(1'b0)) u_dut_unsigned (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_u.slave),
    .state_dbg (state_u)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair on the signed build, then count edges until out_valid.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic smv, input logic [15:0] exp_p, input int exp_lat);
    int lat;
    check({tag, " in_ready"}, 32'(bus_s.in_ready), 32'd1);
    bus_s.in_valid    = 1'b1;
    bus_s.a           = av;
    bus_s.b           = bv;
    bus_s.signed_mode = smv;
    tick();
    bus_s.in_valid    = 1'b0;
    bus_s.a           = 8'($urandom_range(0, 255));
    bus_s.b           = 8'($urandom_range(0, 255));
    bus_s.signed_mode = 1'($urandom_range(0, 1));
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus_s.out_valid) break;
    end
    check({tag, " out_valid"}, 32'(bus_s.out_valid), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " product"}, 32'(bus_s.product), 32'(exp_p));
  endtask

  // One edge with out_ready high consumes the result.
  task automatic consume(input string tag, input logic [15:0] exp_p);
    bus_s.out_ready = 1'b1;
    tick();
    check({tag, " idle in_ready"}, 32'(bus_s.in_ready), 32'd1);
    check({tag, " idle out_valid"}, 32'(bus_s.out_valid), 32'd0);
    check({tag, " product kept"}, 32'(bus_s.product), 32'(exp_p));
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.a = '0; bus_s.b = '0; bus_s.signed_mode = 1'b0; bus_s.out_ready = 1'b1;
    bus_u.in_valid = 1'b0; bus_u.a = '0; bus_u.b = '0; bus_u.signed_mode = 1'b0; bus_u.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 32'(bus_s.in_ready), 32'd1);
    check("reset out_valid", 32'(bus_s.out_valid), 32'd0);
    check("reset busy", 32'(bus_s.busy), 32'd0);
    check("reset product", 32'(bus_s.product), 32'd0);
    check("reset state", 32'(state_s), 32'd0);

    do_op("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F, 5);
    check("u13x11 busy", 32'(bus_s.busy), 32'd1);
    consume("u13x11", 16'h008F);

    do_op("sFDx07", 8'hFD, 8'h07, 1'b1, 16'hFFEB, 4);
    consume("sFDx07", 16'hFFEB);
    do_op("uFDx07", 8'hFD, 8'h07, 1'b0, 16'h06EB, 4);
    consume("uFDx07", 16'h06EB);
    do_op("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 9);
    consume("s80x80", 16'h4000);
    do_op("uFFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9);
    consume("uFFxFF", 16'hFE01);
    do_op("s7Fx80", 8'h7F, 8'h80, 1'b1, 16'hC080, 9);
    consume("s7Fx80", 16'hC080);
    do_op("uABx00", 8'hAB, 8'h00, 1'b0, 16'h0000, 1);
    consume("uABx00", 16'h0000);
    do_op("s00xFF", 8'h00, 8'hFF, 1'b1, 16'h0000, 2);
    consume("s00xFF", 16'h0000);

    // Backpressure: result must hold while stray in_valid pulses are ignored.
    bus_s.out_ready = 1'b0;
    do_op("bp5x3", 8'd5, 8'd3, 1'b0, 16'h000F, 3);
    for (int i = 0; i < 6; i++) begin
      bus_s.in_valid = 1'(i % 2);
      bus_s.a = 8'd200;
      bus_s.b = 8'd100;
      tick();
      check("bp out_valid", 32'(bus_s.out_valid), 32'd1);
      check("bp product", 32'(bus_s.product), 32'h000F);
      check("bp in_ready", 32'(bus_s.in_ready), 32'd0);
    end
    bus_s.in_valid = 1'b0;
    consume("bp5x3", 16'h000F);
    do_op("bp9x9", 8'd9, 8'd9, 1'b0, 16'h0051, 5);
    consume("bp9x9", 16'h0051);

    // Reset two cycles into a long multiply discards it.
    bus_s.in_valid = 1'b1; bus_s.a = 8'hFF; bus_s.b = 8'hFF; bus_s.signed_mode = 1'b0;
    tick();
    bus_s.in_valid = 1'b0;
    tick();
    tick();
    check("midrun busy", 32'(bus_s.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst out_valid", 32'(bus_s.out_valid), 32'd0);
    check("rst product", 32'(bus_s.product), 32'd0);
    check("rst busy", 32'(bus_s.busy), 32'd0);
    check("rst in_ready", 32'(bus_s.in_ready), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("rst no result", 32'(bus_s.out_valid), 32'd0);
    do_op("r6x7", 8'd6, 8'd7, 1'b0, 16'h002A, 4);
    consume("r6x7", 16'h002A);

    // SIGNED_EN=0 build ignores signed_mode.
    check("nsig in_ready", 32'(bus_u.in_ready), 32'd1);
    bus_u.in_valid = 1'b1; bus_u.a = 8'hFD; bus_u.b = 8'h07; bus_u.signed_mode = 1'b1;
    tick();
    bus_u.in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus_u.out_valid) break;
    end
    check("nsig latency", 32'(lat), 32'd4);
    check("nsig product", 32'(bus_u.product), 32'h06EB);
    tick();
    check("nsig idle", 32'(bus_u.in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
